piso_shift_register: RTL and testbench
======================================

Name: piso_shift_register

Overview:
- Parallel-in, serial-out shifter: the transmit-side counterpart to the team's serial-in, parallel-out shift register.
- Accepts an N-bit word through a valid/ready load handshake and emits it one bit per enabled clock, either LSB-first or MSB-first.
- Drives serial links whose far end is the serial-in register.
- Provides bit-valid and last-bit framing, and supports gapless back-to-back words.

Parameters:
- N, 8, word width in bits; legal range N >= 2.
- CW, $clog2(N), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
- enable  input  1  shift enable; a bit is transferred in any cycle with O_valid=1 and enable=1.
- direction  input  1  0 = LSB-first, 1 = MSB-first; sampled only on load acceptance.
- load_valid  input  1  load_data is offered.
- load_data  input  N  parallel word to serialise.
- load_ready  output  1  block can accept a word this cycle.
- O  output  1  current serial bit.
- O_valid  output  1  O holds a live bit of the current word.
- last  output  1  O is the final bit of the word.
- busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; shift register = 0; bit count = 0; latched direction = 0.
  - Outputs: O=0, O_valid=0, last=0, busy=0, load_ready=1.
  - Applies at any time, including mid-word; the partial word is discarded with no further bits or last.
- FSM states IDLE and SHIFT:
  - IDLE: load_ready=1. On a rising edge with load_valid=1:
    - capture load_data and direction;
    - set count=0;
    - go to SHIFT.
  - IDLE ignores enable; loads are accepted whether enable is 0 or 1.
- SHIFT, outputs:
  - O_valid=1, busy=1.
  - O = latched-dir ? sreg[N-1] : sreg[0], driven from the register with no extra latency.
  - The first bit is visible in the cycle after acceptance.
- SHIFT, enable=1 (bit transferred):
  - shift toward the output end (right for LSB-first, left for MSB-first), fill with 0;
  - count increments.
- SHIFT, enable=0: all state holds; O, O_valid and last are unchanged (stall).
- last = SHIFT && count == N-1.
- Final transfer (last=1 and enable=1):
  - load_ready=1 combinationally in that cycle.
  - If load_valid=1 in the same cycle, the new word loads and SHIFT continues with count=0 (gapless; bit 0 of the new word follows directly).
  - Otherwise return to IDLE.
- load_ready=0 in SHIFT except during the final-transfer cycle; a load_valid offered then is not accepted and load_data is not sampled.
- Changing direction while in SHIFT has no effect on the current word.
- Latency:
  - acceptance to first bit = 1 cycle;
  - a word completes in N enabled cycles;
  - sustained throughput is 1 bit/cycle with enable held high.
- Counter compares against N-1 at CW bits; no wrap beyond N-1 is reachable.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=0, ST_SHIFT=1;
  - direction constants DIR_LSB_FIRST=0, DIR_MSB_FIRST=1.
- One natural sub-module, piso_bit_counter:
  - CW-bit counter with clear, increment and terminal flag (count==N-1);
  - asynchronous active-low reset.
- Shift datapath and FSM stay in the top module.

Test Plan:
- Reset then load 8'hB4, direction=0, enable=1 -> O = 0,0,1,0,1,1,0,1 on 8 consecutive cycles; last only on the 8th; O_valid/busy high for exactly 8 cycles; load_ready returns to 1.
- Load 8'hB4, direction=1 -> O = 1,0,1,1,0,1,0,0; last on the 8th bit.
- Load 8'hB4, direction=0, with enable low on cycles 3-5 -> O holds its current bit while stalled; sequence unchanged; word ends 3 cycles later; last not asserted during the stall.
- Back-to-back: load 8'hF0 then hold load_valid with 8'h0F at the final bit, direction=0 -> 16 contiguous bits 0,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0; last on bits 8 and 16; no idle gap.
- Mid-word: toggle direction and pulse load_valid with 8'hFF at bit 3 of an 8'hB4 word -> current word output unchanged; 8'hFF is not accepted.
- Assert reset=0 asynchronously at bit 4 of a word -> outputs go immediately to reset values; after release, load 8'h01 with direction=0 -> O = 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/piso_shift_register_pkg.sv
// Shared types and constants for the PISO shifter.
// State and direction encodings.
package piso_shift_register_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_shift_register_if.sv
// Load handshake and serial output bundle.
// master drives load side; slave is the shifter.
interface piso_shift_register_if #(
  parameter int N = 8
);
  logic         enable;
  logic         direction;
  logic         load_valid;
  logic [N-1:0] load_data;
  logic         load_ready;
  logic         O;
  logic         O_valid;
  logic         last;
  logic         busy;

  modport master (
    output enable, direction, load_valid, load_data,
    input  load_ready, O, O_valid, last, busy
  );

  modport slave (
    input  enable, direction, load_valid, load_data,
    output load_ready, O, O_valid, last, busy
  );
endinterface

// File: rtl/piso_shift_register_bit_counter.sv
// Bit counter: clr/inc, terminal flag at N-1.
// Ports: clk, rst_n, clr, inc -> term.
module piso_bit_counter #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign term = (count_q == CW'(N - 1));

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shifter, LSB/MSB first.
// Ports: clk, reset (async low), bus (slave).
module piso_shift_register
  import piso_shift_register_pkg::*;
#(
  parameter int N = 8
) (
  input logic                 clk,
  input logic                 reset,
  piso_shift_register_if.slave bus
);

  state_e       state_q, state_d;
  logic [N-1:0] sreg_q, sreg_d;
  logic         dir_q, dir_d;

  logic fire;
  logic term;
  logic fin;
  logic accept;
  logic clr;
  logic inc;
  logic shifting;

  assign shifting = (state_q == ST_SHIFT);
  assign fire     = shifting && bus.enable;
  assign fin      = fire && term;

  // Final transfer frees the register in the
  // same cycle so a new word can follow gaplessly.
  assign bus.load_ready = !shifting || fin;
  assign accept = bus.load_valid && bus.load_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    dir_d   = dir_q;
    clr     = 1'b0;
    inc     = 1'b0;
    if (accept) begin
      state_d = ST_SHIFT;
      sreg_d  = bus.load_data;
      dir_d   = bus.direction;
      clr     = 1'b1;
    end else if (fire) begin
      if (dir_q == DIR_MSB_FIRST)
        sreg_d = {sreg_q[N-2:0], 1'b0};
      else
        sreg_d = {1'b0, sreg_q[N-1:1]};
      if (fin) begin
        state_d = ST_IDLE;
        clr     = 1'b1;
      end else begin
        inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      dir_q   <= DIR_LSB_FIRST;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dir_q   <= dir_d;
    end
  end

  piso_bit_counter #(
    .N (N)
  ) u_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (clr),
    .inc   (inc),
    .term  (term)
  );

  assign bus.O = shifting &&
    ((dir_q == DIR_MSB_FIRST) ? sreg_q[N-1]
                              : sreg_q[0]);
  assign bus.O_valid = shifting;
  assign bus.busy    = shifting;
  assign bus.last    = shifting && term;

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register.
// Immediate assertions with hand-computed bits.
module tb_piso_shift_register;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  piso_shift_register_if #(.N(8)) bus ();

  piso_shift_register #(.N(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ovalid"}, 32'(bus.O_valid), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_last"}, 32'(bus.last), 0);
    chk({tag, "_o"}, 32'(bus.O), 0);
    chk({tag, "_ready"}, 32'(bus.load_ready), 1);
  endtask

  task automatic load(input logic [7:0] d,
                      input logic dir);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.direction  = dir;
    #1;
    chk("load_ready", 32'(bus.load_ready), 1);
    tick();
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    #1;
  endtask

  logic [7:0]  seq;
  logic [15:0] seq16;
  int          k;
  logic        en;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.enable     = 1'b0;
    bus.direction  = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    #12;
    chk_idle("rst");
    reset = 1'b1;
    tick();
    chk_idle("post_rst");

    // 8'hB4 LSB-first: 0,0,1,0,1,1,0,1
    bus.enable = 1'b1;
    seq = 8'b0010_1101;
    load(8'hB4, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("lsb_o", 32'(bus.O), 32'(seq[7-i]));
      chk("lsb_ovalid", 32'(bus.O_valid), 1);
      chk("lsb_busy", 32'(bus.busy), 1);
      chk("lsb_last", 32'(bus.last), 32'(i == 7));
      chk("lsb_ready", 32'(bus.load_ready),
          32'(i == 7));
      tick();
    end
    chk_idle("lsb_end");

    // 8'hB4 MSB-first: 1,0,1,1,0,1,0,0
    seq = 8'b1011_0100;
    load(8'hB4, 1'b1);
    bus.direction = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("msb_o", 32'(bus.O), 32'(seq[7-i]));
      chk("msb_last", 32'(bus.last), 32'(i == 7));
      tick();
    end
    chk_idle("msb_end");

    // stall on cycles 3-5
    seq = 8'b0010_1101;
    load(8'hB4, 1'b0);
    k = 0;
    for (int c = 0; c < 11; c++) begin
      en = !(c >= 2 && c <= 4);
      bus.enable = en;
      #1;
      chk("stl_o", 32'(bus.O), 32'(seq[7-k]));
      chk("stl_ovalid", 32'(bus.O_valid), 1);
      chk("stl_last", 32'(bus.last), 32'(k == 7));
      tick();
      if (en) k++;
    end
    bus.enable = 1'b1;
    chk_idle("stl_end");

    // back-to-back F0 then 0F
    seq16 = 16'b0000_1111_1111_0000;
    load(8'hF0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h0F;
        #1;
        chk("b2b_ready", 32'(bus.load_ready), 1);
      end
      chk("b2b_o", 32'(bus.O), 32'(seq16[15-i]));
      chk("b2b_ovalid", 32'(bus.O_valid), 1);
      chk("b2b_last", 32'(bus.last),
          32'(i == 7 || i == 15));
      tick();
      bus.load_valid = 1'b0;
      bus.load_data  = 8'h00;
    end
    #1;
    chk_idle("b2b_end");

    // mid-word direction change + rejected load
    seq = 8'b0010_1101;
    load(8'hB4, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        bus.direction  = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        #1;
        chk("mid_ready", 32'(bus.load_ready), 0);
      end
      chk("mid_o", 32'(bus.O), 32'(seq[7-i]));
      chk("mid_last", 32'(bus.last), 32'(i == 7));
      tick();
      bus.load_valid = 1'b0;
      bus.load_data  = 8'h00;
      bus.direction  = 1'b0;
    end
    #1;
    chk_idle("mid_end");

    // async reset at bit 4
    load(8'hB4, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("ar_pre_ovalid", 32'(bus.O_valid), 1);
    chk("ar_pre_o", 32'(bus.O), 1);
    #1;
    reset = 1'b0;
    #1;
    chk_idle("ar");
    tick();
    reset = 1'b1;
    tick();
    chk_idle("ar_rel");

    // 8'h01 LSB-first: 1,0,0,0,0,0,0,0
    seq = 8'b1000_0000;
    load(8'h01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("one_o", 32'(bus.O), 32'(seq[7-i]));
      chk("one_last", 32'(bus.last), 32'(i == 7));
      tick();
    end
    chk_idle("one_end");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
